dial_lock_controller: RTL and testbench

Sequencing controller for the dial combination lock. It tracks the dial position from rotary step pulses, derives turn direction, and detects direction reversals as digit stops. It checks the three-digit combination Right–Left–Right, then Center, and counts failed attempts into a timed lockout. While open, it lets the user reprogram the combination. It sits between the debounced rotary/button front end and the lock status LEDs.

---
 rtl/dial_lock_controller.sv | 210 +++++++++++++++++++++
 tb/tb_dial_lock_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dial_lock_controller.sv
// dial_lock_controller
//   Sequencing controller for the dial combination lock. Tracks the dial
//   position from rotary step pulses, detects direction reversals as digit
//   stops, checks the Right-Left-Right-Center combination, counts failed
//   attempts into a timed lockout and lets the user reprogram the combination
//   while open.
// Ports
//   Clk            system clock (posedge)
//   South          synchronous active-low reset
//   Cw / Ccw       one-cycle step pulses (+1 / -1); both or neither = hold
//   Center         attempt unlock / commit program digit
//   Prog           enter program mode (only from OPEN)
//   Relock         return to IDLE
//   Count          current dial position
//   Right / Left   direction of last accepted step
//   Locked         low only in OPEN and P1..P3
//   Lockout        high only in LOCKOUT
//   Fails          consecutive failed attempts
//   state          FSM state code
module dial_lock_controller #(
  parameter int POSITIONS      = 20,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int DEF_C0         = 13,
  parameter int DEF_C1         = 7,
  parameter int DEF_C2         = 17
) (
  input  logic       Clk,
  input  logic       South,
  input  logic       Cw,
  input  logic       Ccw,
  input  logic       Center,
  input  logic       Prog,
  input  logic       Relock,
  output logic [4:0] Count,
  output logic       Right,
  output logic       Left,
  output logic       Locked,
  output logic       Lockout,
  output logic [1:0] Fails,
  output logic [3:0] state
);

  localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_S1      = 4'd1,
    ST_S2      = 4'd2,
    ST_S3      = 4'd3,
    ST_OPEN    = 4'd4,
    ST_LOCKOUT = 4'd5,
    ST_P1      = 4'd6,
    ST_P2      = 4'd7,
    ST_P3      = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic            right_q, left_q;
  logic [1:0]      fails_q, fails_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0][4:0] code_q, code_d;     // [0]=C0 .. [2]=C2
  logic [2:0][4:0] stage_q, stage_d;   // digits staged during programming
  logic            locked_q, lockout_q;

  logic step_cw, step_ccw, rev_cw, rev_ccw, fail;

  // Simultaneous Cw and Ccw cancel out and count as no step.
  assign step_cw  = Cw & ~Ccw;
  assign step_ccw = Ccw & ~Cw;
  // A reversal is a step opposite to the latched direction; the stop digit
  // is the position before that step, i.e. count_q.
  assign rev_cw   = step_cw & left_q;
  assign rev_ccw  = step_ccw & right_q;

  always_comb begin
    count_d = count_q;
    if (step_cw)
      count_d = (count_q == 5'(POSITIONS - 1)) ? 5'd0 : count_q + 5'd1;
    else if (step_ccw)
      count_d = (count_q == 5'd0) ? 5'(POSITIONS - 1) : count_q - 5'd1;
  end

  // Each state resolves Relock > Prog > Center > reversal; pulses a state
  // does not honour fall through to the next lower priority.
  always_comb begin
    state_d = state_q;
    fails_d = fails_q;
    timer_d = timer_q;
    code_d  = code_q;
    stage_d = stage_q;
    fail    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!Relock && step_cw) state_d = ST_S1;
      end
      ST_S1: begin
        if (Relock)       state_d = ST_IDLE;
        else if (Center)  fail = 1'b1;
        else if (rev_ccw) begin
          if (count_q == code_q[0]) state_d = ST_S2;
          else                      fail = 1'b1;
        end
      end
      ST_S2: begin
        if (Relock)      state_d = ST_IDLE;
        else if (Center) fail = 1'b1;
        else if (rev_cw) begin
          if (count_q == code_q[1]) state_d = ST_S3;
          else                      fail = 1'b1;
        end
      end
      ST_S3: begin
        if (Relock) state_d = ST_IDLE;
        else if (Center) begin
          if (count_q == code_q[2]) begin
            state_d = ST_OPEN;
            fails_d = 2'd0;
          end else begin
            fail = 1'b1;
          end
        end
        else if (rev_ccw) fail = 1'b1;
      end
      ST_OPEN: begin
        if (Relock)    state_d = ST_IDLE;
        else if (Prog) state_d = ST_P1;
      end
      ST_P1: begin
        if (Relock) state_d = ST_IDLE;
        else if (Center) begin
          stage_d[0] = count_q;
          state_d    = ST_P2;
        end
      end
      ST_P2: begin
        if (Relock) state_d = ST_IDLE;
        else if (Center) begin
          stage_d[1] = count_q;
          state_d    = ST_P3;
        end
      end
      ST_P3: begin
        if (Relock) state_d = ST_IDLE;
        else if (Center) begin
          // All three digits land together so an abort never leaves a mix.
          code_d  = {count_q, stage_q[1], stage_q[0]};
          state_d = ST_OPEN;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
          fails_d = 2'd0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      fails_d = fails_q + 2'd1;
      if (fails_d == 2'(MAX_FAILS)) begin
        state_d = ST_LOCKOUT;
        timer_d = TW'(LOCKOUT_CYCLES - 1);
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!South) begin
      state_q   <= ST_IDLE;
      count_q   <= 5'd0;
      right_q   <= 1'b0;
      left_q    <= 1'b0;
      fails_q   <= 2'd0;
      timer_q   <= '0;
      code_q    <= {5'(DEF_C2), 5'(DEF_C1), 5'(DEF_C0)};
      stage_q   <= '0;
      locked_q  <= 1'b1;
      lockout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (step_cw | step_ccw) begin
        right_q <= step_cw;
        left_q  <= step_ccw;
      end
      fails_q   <= fails_d;
      timer_q   <= timer_d;
      code_q    <= code_d;
      stage_q   <= stage_d;
      locked_q  <= !(state_d inside {ST_OPEN, ST_P1, ST_P2, ST_P3});
      lockout_q <= (state_d == ST_LOCKOUT);
    end
  end

  assign Count   = count_q;
  assign Right   = right_q;
  assign Left    = left_q;
  assign Locked  = locked_q;
  assign Lockout = lockout_q;
  assign Fails   = fails_q;
  assign state   = state_q;

endmodule

// File: tb/tb_dial_lock_controller.sv
// Bench for dial_lock_controller: directed scenarios with literal
// expectations, then randomized pulses, all compared every cycle against a
// behavioural model of the lock.
module tb_dial_lock_controller;
  localparam int POS = 20, MAXF = 3, LOCK = 1000, C0 = 13, C1 = 7, C2 = 17;

  logic       Clk, South, Cw, Ccw, Center, Prog, Relock;
  logic [4:0] Count;
  logic       Right, Left, Locked, Lockout;
  logic [1:0] Fails;
  logic [3:0] state;

  int checks = 0, failures = 0;
  bit chk_en = 0;

  // model: position, direction (+1/-1/0), mode code, fails, remaining lockout
  int m_pos, m_dir, m_st, m_fails, m_left;
  int m_code[3], m_stage[3];

  dial_lock_controller #(.POSITIONS(POS), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK),
    .DEF_C0(C0), .DEF_C1(C1), .DEF_C2(C2)) dut (
    .Clk(Clk), .South(South), .Cw(Cw), .Ccw(Ccw), .Center(Center), .Prog(Prog),
    .Relock(Relock), .Count(Count), .Right(Right), .Left(Left), .Locked(Locked),
    .Lockout(Lockout), .Fails(Fails), .state(state));

  initial Clk = 0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge Clk) begin : mdl
    int mv, stop;
    bit rev, fail, c_eff, p_eff;
    if (!South) begin
      m_pos = 0; m_dir = 0; m_st = 0; m_fails = 0; m_left = 0;
      m_code[0] = C0; m_code[1] = C1; m_code[2] = C2;
      m_stage[0] = 0; m_stage[1] = 0; m_stage[2] = 0;
    end else begin
      mv    = (Cw && !Ccw) ? 1 : (Ccw && !Cw) ? -1 : 0;
      stop  = m_pos;
      rev   = (mv != 0) && (m_dir == -mv);
      fail  = 0;
      c_eff = Center && (m_st inside {1, 2, 3, 6, 7, 8});
      p_eff = Prog && (m_st == 4);
      if (m_st == 5) begin
        m_left--;
        if (m_left == 0) begin m_st = 0; m_fails = 0; end
      end
      else if (Relock) m_st = 0;
      else if (p_eff)  m_st = 6;
      else if (c_eff) begin
        if (m_st == 3 && stop == m_code[2]) begin m_st = 4; m_fails = 0; end
        else if (m_st >= 6) begin
          m_stage[m_st-6] = stop;
          if (m_st == 8) begin m_code = m_stage; m_st = 4; end
          else m_st++;
        end
        else fail = 1;
      end
      else if (m_st == 0) begin
        if (mv == 1) m_st = 1;
      end
      else if (rev) begin
        if (m_st == 1 && mv == -1) begin
          if (stop == m_code[0]) m_st = 2; else fail = 1;
        end else if (m_st == 2 && mv == 1) begin
          if (stop == m_code[1]) m_st = 3; else fail = 1;
        end else if (m_st == 3 && mv == -1) fail = 1;
      end
      if (fail) begin
        m_fails++;
        if (m_fails == MAXF) begin m_st = 5; m_left = LOCK; end
        else m_st = 0;
      end
      if (mv != 0) begin
        m_pos = (m_pos + mv + POS) % POS;
        m_dir = mv;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("Count", int'(Count), m_pos);
      chk("Right", int'(Right), int'(m_dir == 1));
      chk("Left", int'(Left), int'(m_dir == -1));
      chk("Locked", int'(Locked), int'(!(m_st inside {4, 6, 7, 8})));
      chk("Lockout", int'(Lockout), int'(m_st == 5));
      chk("Fails", int'(Fails), m_fails);
      chk("state", int'(state), m_st);
    end
  end

  task automatic cyc(input bit cw, input bit ccw, input bit ctr, input bit prg, input bit rl);
    Cw = cw; Ccw = ccw; Center = ctr; Prog = prg; Relock = rl;
    @(posedge Clk); #2;
    Cw = 0; Ccw = 0; Center = 0; Prog = 0; Relock = 0;
  endtask

  task automatic do_reset();
    South = 0; cyc(0, 0, 0, 0, 0); South = 1;
  endtask

  task automatic step_to(input int dirv, input int target);
    int n = 0;
    do begin
      cyc(dirv == 1, dirv == -1, 0, 0, 0);
      n++;
    end while (m_pos != target && n < 64);
    if (m_pos != target) chk("step_to_bound", m_pos, target);
  endtask

  task automatic try_code(input int a, input int b, input int c);
    step_to(1, a); step_to(-1, b); step_to(1, c); cyc(0, 0, 1, 0, 0);
  endtask

  task automatic three_fails();
    for (int k = 0; k < 3; k++) begin
      step_to(1, 12); cyc(0, 1, 0, 0, 0);
      if (k < 2) chk("fail_count", int'(Fails), k + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    South = 0; Cw = 0; Ccw = 0; Center = 0; Prog = 0; Relock = 0;
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    South = 1; chk_en = 1;
    chk("rst_Count", int'(Count), 0);
    chk("rst_Locked", int'(Locked), 1);
    chk("rst_state", int'(state), 0);
    chk("rst_dir", int'({Right, Left}), 0);

    // default combination 13/7/17
    for (int i = 0; i < 13; i++) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)  cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("open_Locked", int'(Locked), 0);
    chk("open_state", int'(state), 4);
    chk("open_Count", int'(Count), 17);
    chk("open_Fails", int'(Fails), 0);

    // wrap and direction from IDLE
    do_reset();
    cyc(0, 1, 0, 0, 0);
    chk("wrap_Count", int'(Count), 19);
    chk("wrap_Left", int'(Left), 1);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0);
    chk("rev_Count", int'(Count), 19);
    chk("rev_Right", int'(Right), 1);
    chk("rev_state", int'(state), 1);

    // lockout after three wrong first stops
    do_reset();
    three_fails();
    chk("lock_enter", int'(Lockout), 1);
    n = 0;
    while (Lockout && n < 2000) begin
      n++;
      cyc($urandom_range(0, 1), 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    chk("lock_cycles", n, LOCK);
    chk("lock_exit_state", int'(state), 0);
    chk("lock_exit_Fails", int'(Fails), 0);

    // reprogram to 3/9/15
    do_reset();
    try_code(13, 7, 17);
    cyc(0, 0, 0, 1, 0);
    chk("prog_state", int'(state), 6);
    step_to(1, 3);  cyc(0, 0, 1, 0, 0);
    step_to(1, 9);  cyc(0, 0, 1, 0, 0);
    step_to(1, 15); cyc(0, 0, 1, 0, 0);
    chk("commit_state", int'(state), 4);
    cyc(0, 0, 0, 0, 1);
    try_code(3, 9, 15);
    chk("newcode_state", int'(state), 4);
    cyc(0, 0, 0, 0, 1);
    try_code(13, 7, 17);
    chk("oldcode_Locked", int'(Locked), 1);
    chk("oldcode_Fails", int'(Fails), 2);
    try_code(3, 9, 15);
    chk("reopen_state", int'(state), 4);
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1);
    chk("abort_state", int'(state), 0);
    try_code(3, 9, 15);
    chk("abort_keeps_code", int'(state), 4);

    // simultaneous steps hold; Relock beats Center
    cyc(1, 1, 0, 0, 0);
    chk("hold_Count", int'(Count), 15);
    chk("hold_Right", int'(Right), 1);
    cyc(0, 0, 1, 0, 1);
    chk("relock_state", int'(state), 0);

    // reset in the middle of lockout
    three_fails();
    for (int i = 0; i < 300; i++) cyc(0, 0, 0, 0, 0);
    chk("midlock_Lockout", int'(Lockout), 1);
    do_reset();
    chk("rstlock_Lockout", int'(Lockout), 0);
    chk("rstlock_state", int'(state), 0);
    chk("rstlock_Count", int'(Count), 0);
    try_code(13, 7, 17);
    chk("rstlock_default", int'(Locked), 0);

    // randomized rounds: open with the model's current code, then churn
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 1200 && m_st == 5; k++) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      try_code(m_code[0], m_code[1], m_code[2]);
      for (int i = 0; i < 600; i++) begin
        int rv;
        rv = $urandom_range(0, 99);
        South = !($urandom_range(0, 799) == 0);
        cyc(rv < 40, rv >= 35 && rv < 75, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0);
        South = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
